// File: rtl/pcap_pkg.sv
// Shared types and helpers for the pcap replay stream arbiter.
package pcap_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int IFG_W   = 8;
    localparam int MAX_SRC = 16;

    // Round-robin search: first set bit in mask starting at last+1, wrapping modulo num_src.
    function automatic logic [3:0] rr_next(input logic [MAX_SRC-1:0] mask,
                                           input logic [3:0]         last,
                                           input int                 num_src);
        logic [3:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = (int'(last) + k) % num_src;
            if (!found && (k <= num_src) && mask[idx[3:0]]) begin
                win   = 4'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry output register with valid/ready hold; accepts a new beat
// whenever it is empty or being drained in the same cycle.
module axis_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] data_reg;
    logic         valid_reg;

    assign in_ready  = !valid_reg || out_ready;
    assign out_data  = data_reg;
    assign out_valid = valid_reg;

    // Load on accept, drop valid once drained, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (in_valid && in_ready) begin
            data_reg  <= in_data;
            valid_reg <= 1'b1;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/pcap_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC packet streams onto one
// registered output, with a programmable gap after each packet.
module pcap_stream_arbiter
    import pcap_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int AXIS_WIDTH = 64,
    parameter int MIN_IFG    = 0,
    localparam int SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC*AXIS_WIDTH-1:0]  s_data,
    input  logic [NUM_SRC*AXIS_WIDTH/8-1:0] s_strb,
    input  logic [NUM_SRC-1:0]             s_valid,
    input  logic [NUM_SRC-1:0]             s_sop,
    input  logic [NUM_SRC-1:0]             s_eop,
    output logic [NUM_SRC-1:0]             s_ready,
    input  logic [NUM_SRC-1:0]             src_enable,
    output logic [AXIS_WIDTH-1:0]          m_data,
    output logic [AXIS_WIDTH/8-1:0]        m_strb,
    output logic                           m_valid,
    output logic                           m_sop,
    output logic                           m_eop,
    input  logic                           m_ready,
    output logic [SEL_W-1:0]               grant_id,
    output logic                           busy,
    output logic [31:0]                    pkt_count,
    output logic                           proto_err
);

    localparam int STRB_W = AXIS_WIDTH / 8;
    localparam int PW     = AXIS_WIDTH + STRB_W + 2;

    arb_state_t         state_reg, state_next;
    logic [SEL_W-1:0]   grant_id_reg, grant_id_next;
    logic [SEL_W-1:0]   last_reg, last_next;
    logic               busy_reg, busy_next;
    logic [IFG_W-1:0]   ifg_cnt_reg, ifg_cnt_next;
    logic               first_beat_reg, first_beat_next;
    logic [31:0]        pkt_count_reg, pkt_count_next;
    logic               proto_err_reg, proto_err_next;

    logic [AXIS_WIDTH-1:0] src_data [NUM_SRC];
    logic [STRB_W-1:0]     src_strb [NUM_SRC];
    logic [NUM_SRC-1:0]    cand_mask, bad_mask;
    logic [SEL_W-1:0]      winner;

    logic          sel_valid, sel_sop, sel_eop;
    logic          slice_in_valid, slice_in_ready, accept;
    logic [PW-1:0] slice_in_data, slice_out_data;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_data[gi] = s_data[gi*AXIS_WIDTH +: AXIS_WIDTH];
            assign src_strb[gi] = s_strb[gi*STRB_W +: STRB_W];
            // Only the locked source sees ready, and only while the output register can take a beat.
            assign s_ready[gi]  = (state_reg == XFER) && (grant_id_reg == SEL_W'(gi)) && slice_in_ready;
        end
    endgenerate

    assign cand_mask = s_valid & s_sop & src_enable;
    assign bad_mask  = s_valid & ~s_sop & src_enable;
    assign winner    = SEL_W'(rr_next(MAX_SRC'(cand_mask), 4'(last_reg), NUM_SRC));

    assign sel_valid      = s_valid[grant_id_reg];
    assign sel_sop        = s_sop[grant_id_reg];
    assign sel_eop        = s_eop[grant_id_reg];
    assign slice_in_valid = (state_reg == XFER) && sel_valid;
    assign accept         = slice_in_valid && slice_in_ready;
    assign slice_in_data  = {src_data[grant_id_reg], src_strb[grant_id_reg], sel_sop, sel_eop};

    axis_reg_slice #(.W(PW)) u_out_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (slice_in_data),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .out_data  (slice_out_data),
        .out_valid (m_valid),
        .out_ready (m_ready)
    );

    assign {m_data, m_strb, m_sop, m_eop} = slice_out_data;
    assign grant_id  = grant_id_reg;
    assign busy      = busy_reg;
    assign pkt_count = pkt_count_reg;
    assign proto_err = proto_err_reg;

    // Next-state logic: arbitration, packet lock, gap countdown, counters and error flag.
    always_comb begin
        state_next      = state_reg;
        grant_id_next   = grant_id_reg;
        last_next       = last_reg;
        busy_next       = busy_reg;
        ifg_cnt_next    = ifg_cnt_reg;
        first_beat_next = first_beat_reg;
        proto_err_next  = proto_err_reg;
        pkt_count_next  = pkt_count_reg + 32'(m_valid && m_ready && m_eop);
        case (state_reg)
            ARB: begin
                if (|bad_mask) proto_err_next = 1'b1;
                if (|cand_mask) begin
                    grant_id_next   = winner;
                    last_next       = winner;
                    busy_next       = 1'b1;
                    first_beat_next = 1'b1;
                    state_next      = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    first_beat_next = 1'b0;
                    // A second sop inside a locked packet is flagged but still forwarded.
                    if (sel_sop && !first_beat_reg) proto_err_next = 1'b1;
                    if (sel_eop) begin
                        busy_next = 1'b0;
                        if (MIN_IFG > 0) begin
                            state_next   = GAP;
                            ifg_cnt_next = IFG_W'(MIN_IFG);
                        end else begin
                            state_next = ARB;
                        end
                    end
                end
            end
            GAP: begin
                if (ifg_cnt_reg <= IFG_W'(1)) begin
                    state_next   = ARB;
                    ifg_cnt_next = '0;
                end else begin
                    ifg_cnt_next = ifg_cnt_reg - IFG_W'(1);
                end
            end
            default: state_next = ARB;
        endcase
    end

    // State register; last starts at NUM_SRC-1 so source 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB;
            grant_id_reg   <= '0;
            last_reg       <= SEL_W'(NUM_SRC - 1);
            busy_reg       <= 1'b0;
            ifg_cnt_reg    <= '0;
            first_beat_reg <= 1'b0;
            pkt_count_reg  <= '0;
            proto_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_id_reg   <= grant_id_next;
            last_reg       <= last_next;
            busy_reg       <= busy_next;
            ifg_cnt_reg    <= ifg_cnt_next;
            first_beat_reg <= first_beat_next;
            pkt_count_reg  <= pkt_count_next;
            proto_err_reg  <= proto_err_next;
        end
    end

endmodule
